sliding_window_gen: RTL and testbench

Line-buffer sliding-window generator that sits directly upstream of conv2d_hls. It accepts a raster-order pixel stream, one pixel per beat, for an IMG_H x IMG_W single-channel frame. It emits every K x K window (stride 1, no padding) as one flattened word per beat. The output uses a valid/ready handshake so the downstream convolution PE array can apply backpressure.

---
 rtl/sliding_window_gen.sv | 117 +++++++++++
 tb/tb_sliding_window_gen.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_gen.sv
// Line-buffer sliding-window generator: turns a raster pixel stream into
// every KxK stride-1 window of an IMG_H x IMG_W frame, one window per beat.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   data_in, valid_in, ready_in   input pixel stream (valid/ready)
//   win_out, valid_out, ready_out flattened window stream (valid/ready)
//   last_out                      marks the final window of a frame
module sliding_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         valid_in,
    output logic                         ready_in,
    output logic [K*K*DATA_WIDTH-1:0]    win_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic                         last_out
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  complete;

    // lbuf[j] holds the row j+1 above the current row; not reset
    logic [DATA_WIDTH-1:0] lbuf [K-1][IMG_W];
    logic [DATA_WIDTH-1:0] win  [K][K];
    logic [DATA_WIDTH-1:0] new_col [K];

    assign ready_in = !rst && (!valid_out || ready_out);
    assign accept   = valid_in && ready_in;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign complete = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

    // Incoming right column, top (oldest row) to bottom (data_in)
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            new_col[i] = lbuf[K-2-i][col];
        end
        new_col[K-1] = data_in;
    end

    // Vertical shift of the column held in the line buffers
    always_ff @(posedge clk) begin
        if (accept) begin
            lbuf[0][col] <= data_in;
            for (int j = 1; j < K - 1; j++) begin
                lbuf[j][col] <= lbuf[j-1][col];
            end
        end
    end

    // Window register: shift left, new column enters on the right.
    // Stalls naturally hold it, since no accept happens while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][K-1] <= new_col[i];
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            assign win_out[(gi*K+gj)*DATA_WIDTH +: DATA_WIDTH] = win[gi][gj];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (accept) begin
            valid_out <= complete;
            last_out  <= complete && row_last && col_last;
        end else if (ready_out) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sliding_window_gen.sv
// Testbench for sliding_window_gen: two instances (4x4 and 8x3 frames),
// windows compared against an array-indexed reference model.
module tb_sliding_window_gen;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int WA = 4;
    localparam int HA = 4;
    localparam int WB = 8;
    localparam int HB = 3;
    localparam int OW = K * K * DW;

    typedef logic [OW-1:0] win_t;
    typedef int arr9_t[9];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic          rst_a = 1'b1;
    logic [DW-1:0] din_a = '0;
    logic          vin_a = 1'b0;
    logic          rin_a;
    win_t          wout_a;
    logic          vout_a;
    logic          rout_a = 1'b1;
    logic          lout_a;

    logic          rst_b = 1'b1;
    logic [DW-1:0] din_b = '0;
    logic          vin_b = 1'b0;
    logic          rin_b;
    win_t          wout_b;
    logic          vout_b;
    logic          rout_b = 1'b1;
    logic          lout_b;

    sliding_window_gen #(.DATA_WIDTH(DW), .IMG_W(WA), .IMG_H(HA), .K(K)) dut_a (
        .clk(clk), .rst(rst_a), .data_in(din_a), .valid_in(vin_a),
        .ready_in(rin_a), .win_out(wout_a), .valid_out(vout_a),
        .ready_out(rout_a), .last_out(lout_a)
    );

    sliding_window_gen #(.DATA_WIDTH(DW), .IMG_W(WB), .IMG_H(HB), .K(K)) dut_b (
        .clk(clk), .rst(rst_b), .data_in(din_b), .valid_in(vin_b),
        .ready_in(rin_b), .win_out(wout_b), .valid_out(vout_b),
        .ready_out(rout_b), .last_out(lout_b)
    );

    win_t got_win[$];
    bit   got_last[$];
    int   got_cyc[$];
    win_t gotb_win[$];
    bit   gotb_last[$];

    always @(negedge clk) begin
        if (vout_a && rout_a) begin
            got_win.push_back(wout_a);
            got_last.push_back(lout_a);
            got_cyc.push_back(cyc);
        end
        if (vout_b && rout_b) begin
            gotb_win.push_back(wout_b);
            gotb_last.push_back(lout_b);
        end
    end

    int   pix_q[$];
    win_t exp_win[$];
    bit   exp_last[$];
    int   exp_pix[$];
    int   acc_cyc[$];
    win_t st_win[$];
    bit   st_rdy[$];

    // Reference: every KxK window of each frame, read straight from pix_q
    task automatic build_model(input int w, input int h);
        int nf;
        win_t v;
        exp_win.delete();
        exp_last.delete();
        exp_pix.delete();
        nf = pix_q.size() / (w * h);
        for (int f = 0; f < nf; f++)
            for (int r = K - 1; r < h; r++)
                for (int c = K - 1; c < w; c++) begin
                    v = '0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            v[(i*K+j)*DW +: DW] =
                                DW'(pix_q[f*w*h + (r-K+1+i)*w + (c-K+1+j)]);
                    exp_win.push_back(v);
                    exp_last.push_back(r == h - 1 && c == w - 1);
                    exp_pix.push_back(f*w*h + r*w + c);
                end
    endtask

    function automatic win_t pack9(input arr9_t a);
        win_t v = '0;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(a[k]);
        return v;
    endfunction

    task automatic ramp(input int n, input int base);
        for (int p = 0; p < n; p++) pix_q.push_back(base + p);
    endtask

    task automatic clear_got();
        got_win.delete();
        got_last.delete();
        got_cyc.delete();
    endtask

    // vmode: 0 always valid, 1 toggle 1/0, 2 random
    // rmode: 0 always ready, 1 one 5-cycle stall at first window, 2 random
    task automatic drive_a(input int vmode, input int rmode, input int drain);
        int idx = 0;
        int budget = 0;
        int stall = 0;
        bit stalled = 1'b0;
        bit tog = 1'b1;
        bit acc;
        acc_cyc.delete();
        st_win.delete();
        st_rdy.delete();
        while (idx < pix_q.size() && budget < 2000) begin
            din_a = DW'(pix_q[idx]);
            case (vmode)
                0: vin_a = 1'b1;
                1: vin_a = tog;
                default: vin_a = ($urandom_range(0, 3) != 0);
            endcase
            if (rmode == 1 && !stalled && vout_a) begin
                stalled = 1'b1;
                stall = 5;
            end
            case (rmode)
                0: rout_a = 1'b1;
                1: rout_a = (stall == 0);
                default: rout_a = ($urandom_range(0, 2) != 0);
            endcase
            @(negedge clk);
            acc = vin_a && rin_a;
            if (stall > 0) begin
                st_win.push_back(wout_a);
                st_rdy.push_back(rin_a);
            end
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (stall > 0) stall--;
            budget++;
            tog = ~tog;
        end
        checks++;
        if (idx != pix_q.size()) begin
            failures++;
            $display("FAIL drive_timeout accepted=%0d required=%0d", idx, pix_q.size());
        end
        vin_a = 1'b0;
        rout_a = 1'b1;
        repeat (drain) @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        vin_a = 1'b0;
        rout_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        vin_a = 1'b1;
        vin_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (vout_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", vout_a);
        end
        if (lout_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_last got=%b exp=0", lout_a);
        end
        if (rin_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready_in got=%b exp=0", rin_a);
        end
        if (wout_a !== '0) begin
            failures++;
            $display("FAIL rst_win got=%h exp=0", wout_a);
        end
        if (vout_b !== 1'b0 || rin_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_b got=%b%b exp=00", vout_b, rin_b);
        end
        @(posedge clk);
        #1;
        vin_a = 1'b0;
        vin_b = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_stream();
        arr9_t lit;
        pix_q.delete();
        ramp(16, 0);
        build_model(WA, HA);
        clear_got();
        drive_a(0, 0, 4);
        checks++;
        if (got_win.size() != 4) begin
            failures++;
            $display("FAIL s1_count got=%0d exp=4", got_win.size());
        end
        for (int k = 0; k < 4 && k < got_win.size(); k++) begin
            checks += 3;
            if (got_win[k] !== exp_win[k]) begin
                failures++;
                $display("FAIL s1_win[%0d] got=%h exp=%h", k, got_win[k], exp_win[k]);
            end
            if (got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s1_last[%0d] got=%b exp=%b", k, got_last[k], exp_last[k]);
            end
            if (got_cyc[k] != acc_cyc[exp_pix[k]] + 1) begin
                failures++;
                $display("FAIL s1_latency[%0d] got=%0d exp=%0d", k, got_cyc[k],
                         acc_cyc[exp_pix[k]] + 1);
            end
        end
        if (got_win.size() == 4) begin
            checks += 2;
            lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
            if (got_win[0] !== pack9(lit)) begin
                failures++;
                $display("FAIL s1_first got=%h exp=%h", got_win[0], pack9(lit));
            end
            lit = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
            if (got_win[3] !== pack9(lit)) begin
                failures++;
                $display("FAIL s1_fourth got=%h exp=%h", got_win[3], pack9(lit));
            end
        end
    endtask

    task automatic test_backpressure();
        arr9_t lit;
        lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        reset_a();
        pix_q.delete();
        ramp(16, 0);
        build_model(WA, HA);
        clear_got();
        drive_a(0, 1, 4);
        checks++;
        if (st_win.size() != 5) begin
            failures++;
            $display("FAIL s2_stall_len got=%0d exp=5", st_win.size());
        end
        for (int k = 0; k < st_win.size(); k++) begin
            checks += 2;
            if (st_win[k] !== pack9(lit)) begin
                failures++;
                $display("FAIL s2_hold[%0d] got=%h exp=%h", k, st_win[k], pack9(lit));
            end
            if (st_rdy[k] !== 1'b0) begin
                failures++;
                $display("FAIL s2_ready_in[%0d] got=%b exp=0", k, st_rdy[k]);
            end
        end
        checks++;
        if (got_win.size() != 4) begin
            failures++;
            $display("FAIL s2_count got=%0d exp=4", got_win.size());
        end
        for (int k = 0; k < 4 && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s2_win[%0d] got=%h/%b exp=%h/%b", k, got_win[k],
                         got_last[k], exp_win[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_valid_toggle();
        reset_a();
        pix_q.delete();
        ramp(16, 0);
        build_model(WA, HA);
        clear_got();
        drive_a(1, 0, 4);
        checks++;
        if (got_win.size() != 4) begin
            failures++;
            $display("FAIL s3_count got=%0d exp=4", got_win.size());
        end
        for (int k = 0; k < 4 && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s3_win[%0d] got=%h/%b exp=%h/%b", k, got_win[k],
                         got_last[k], exp_win[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        arr9_t lit;
        lit = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        reset_a();
        pix_q.delete();
        ramp(16, 0);
        ramp(16, 100);
        build_model(WA, HA);
        clear_got();
        drive_a(0, 0, 4);
        checks++;
        if (got_win.size() != 8) begin
            failures++;
            $display("FAIL s4_count got=%0d exp=8", got_win.size());
        end
        for (int k = 0; k < 8 && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s4_win[%0d] got=%h/%b exp=%h/%b", k, got_win[k],
                         got_last[k], exp_win[k], exp_last[k]);
            end
        end
        if (got_win.size() > 4) begin
            checks++;
            if (got_win[4] !== pack9(lit)) begin
                failures++;
                $display("FAIL s4_f2_first got=%h exp=%h", got_win[4], pack9(lit));
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        pix_q.delete();
        ramp(10, 0);
        clear_got();
        drive_a(0, 0, 0);
        rst_a = 1'b1;
        vin_a = 1'b1;
        din_a = 8'd10;
        @(negedge clk);
        checks++;
        if (rin_a !== 1'b0) begin
            failures++;
            $display("FAIL s5_ready_in got=%b exp=0", rin_a);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        vin_a = 1'b0;
        checks++;
        if (vout_a !== 1'b0 || got_win.size() != 0) begin
            failures++;
            $display("FAIL s5_valid got=%b/%0d exp=0/0", vout_a, got_win.size());
        end
        // Reset while a completed window is still pending
        pix_q.delete();
        ramp(11, 0);
        drive_a(0, 0, 0);
        rst_a = 1'b1;
        rout_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rout_a = 1'b1;
        checks++;
        if (vout_a !== 1'b0) begin
            failures++;
            $display("FAIL s5_drop got=%b exp=0", vout_a);
        end
        pix_q.delete();
        ramp(16, 0);
        build_model(WA, HA);
        clear_got();
        drive_a(0, 0, 4);
        checks++;
        if (got_win.size() != 4) begin
            failures++;
            $display("FAIL s5_count got=%0d exp=4", got_win.size());
        end
        for (int k = 0; k < 4 && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s5_win[%0d] got=%h/%b exp=%h/%b", k, got_win[k],
                         got_last[k], exp_win[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_random();
        reset_a();
        pix_q.delete();
        for (int p = 0; p < 2 * WA * HA; p++) pix_q.push_back(int'($urandom_range(0, 255)));
        build_model(WA, HA);
        clear_got();
        drive_a(2, 2, 6);
        checks++;
        if (got_win.size() != exp_win.size()) begin
            failures++;
            $display("FAIL rnd_count got=%0d exp=%0d", got_win.size(), exp_win.size());
        end
        for (int k = 0; k < exp_win.size() && k < got_win.size(); k++) begin
            checks++;
            if (got_win[k] !== exp_win[k] || got_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL rnd_win[%0d] got=%h/%b exp=%h/%b", k, got_win[k],
                         got_last[k], exp_win[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_small_frame();
        int idx = 0;
        int budget = 0;
        bit acc;
        pix_q.delete();
        ramp(WB * HB, 0);
        build_model(WB, HB);
        gotb_win.delete();
        gotb_last.delete();
        rout_b = 1'b1;
        while (idx < pix_q.size() && budget < 200) begin
            din_b = DW'(pix_q[idx]);
            vin_b = 1'b1;
            @(negedge clk);
            acc = rin_b;
            @(posedge clk);
            #1;
            if (acc) idx++;
            budget++;
        end
        vin_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gotb_win.size() != 6 || idx != pix_q.size()) begin
            failures++;
            $display("FAIL s6_count got=%0d exp=6", gotb_win.size());
        end
        for (int k = 0; k < 6 && k < gotb_win.size(); k++) begin
            checks++;
            if (gotb_win[k] !== exp_win[k] || gotb_last[k] !== exp_last[k]) begin
                failures++;
                $display("FAIL s6_win[%0d] got=%h/%b exp=%h/%b", k, gotb_win[k],
                         gotb_last[k], exp_win[k], exp_last[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_valid_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_small_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
